// File: rtl/pwm_multi.sv
// N-channel PWM generator sharing one period counter (up, down, center-aligned).
// Shadow period/compare/polarity/mode inputs are adopted only at a period boundary.
module pwm_multi #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           clk50m,
  input  logic           rst_n,
  input  logic           en,
  input  logic [1:0]     mode,
  input  logic [W-1:0]   per,
  input  logic [N*W-1:0] cmp,
  input  logic [N-1:0]   pol,
  input  logic           upd,
  output logic [W-1:0]   cnt,
  output logic [N-1:0]   pwm,
  output logic           period_end,
  output logic           upd_pend
);

  localparam logic [1:0]   M_DOWN = 2'b01;
  localparam logic [1:0]   M_UD   = 2'b10;
  localparam logic [W-1:0] ONE    = W'(1);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  logic [W-1:0]   r_cnt;
  dir_t           r_dir;
  logic [W-1:0]   r_per_a;
  logic [N*W-1:0] r_cmp_a;
  logic [N-1:0]   r_pol_a;
  logic [1:0]     r_mode_a;
  logic [N-1:0]   r_pwm;
  logic           r_period_end;
  logic           r_upd_pend;

  logic           w_lc;
  logic           w_boundary;
  logic           w_load;
  logic [W-1:0]   w_per_next;
  logic [N*W-1:0] w_cmp_next;
  logic [N-1:0]   w_pol_next;
  logic [1:0]     w_mode_next;
  logic [W-1:0]   w_cnt_next;
  dir_t           w_dir_next;
  logic [N-1:0]   w_pwm_next;

  // Last cycle of the current period; mode 11 falls into the up branch.
  always_comb begin
    case (r_mode_a)
      M_DOWN:  w_lc = (r_cnt == '0);
      M_UD:    w_lc = (r_per_a == '0) ||
                      ((r_cnt == ONE) && ((r_dir == DIR_DOWN) || (r_per_a == ONE)));
      default: w_lc = (r_cnt >= r_per_a);
    endcase
  end

  assign w_boundary  = en && w_lc;
  assign w_load      = w_boundary && (r_upd_pend || upd);
  assign w_per_next  = w_load ? per  : r_per_a;
  assign w_cmp_next  = w_load ? cmp  : r_cmp_a;
  assign w_pol_next  = w_load ? pol  : r_pol_a;
  assign w_mode_next = w_load ? mode : r_mode_a;

  always_comb begin
    w_cnt_next = r_cnt;
    w_dir_next = r_dir;
    if (w_boundary) begin
      w_dir_next = DIR_UP;
      w_cnt_next = (w_mode_next == M_DOWN) ? w_per_next : '0;
    end else if (en) begin
      case (r_mode_a)
        M_DOWN: w_cnt_next = r_cnt - ONE;
        M_UD: begin
          if (r_dir == DIR_DOWN) begin
            w_cnt_next = r_cnt - ONE;
          end else if (r_cnt < r_per_a) begin
            w_cnt_next = r_cnt + ONE;
          end else begin
            w_cnt_next = r_cnt - ONE;
            w_dir_next = DIR_DOWN;
          end
        end
        default: w_cnt_next = r_cnt + ONE;
      endcase
    end
  end

  // Outputs are derived from next-state values so pwm lines up with cnt.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      assign w_pwm_next[gi] = w_pol_next[gi] ^ (w_cnt_next < w_cmp_next[gi*W +: W]);
    end
  endgenerate

  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_dir        <= DIR_UP;
      r_per_a      <= '0;
      r_cmp_a      <= '0;
      r_pol_a      <= '0;
      r_mode_a     <= '0;
      r_pwm        <= '0;
      r_period_end <= 1'b0;
      r_upd_pend   <= 1'b1;
    end else begin
      r_cnt        <= w_cnt_next;
      r_dir        <= w_dir_next;
      r_per_a      <= w_per_next;
      r_cmp_a      <= w_cmp_next;
      r_pol_a      <= w_pol_next;
      r_mode_a     <= w_mode_next;
      r_pwm        <= w_pwm_next;
      r_period_end <= w_boundary;
      r_upd_pend   <= w_boundary ? 1'b0 : (r_upd_pend || upd);
    end
  end

  assign cnt        = r_cnt;
  assign pwm        = r_pwm;
  assign period_end = r_period_end;
  assign upd_pend   = r_upd_pend;

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- N-channel PWM generator built around one shared period counter.
- Successor to the single-channel counter/PWM block, with three additions: up, down and center-aligned (up-down) count modes; a per-channel output polarity; double-buffered period, compare, polarity and mode registers that reload only at a period boundary, so there are no glitches mid-period.
- Sits between the control register file and the motor/LED driver pins.

Parameters:
- W, 8, counter/period/compare width in bits.
- N, 4, number of PWM channels.

Ports:
- clk50m  in  1  system clock, rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  count enable.
- mode  in  2  count mode: 00 up, 01 down, 10 up-down, 11 treated as up.
- per  in  W  period value (shadow input).
- cmp  in  N*W  compare values; channel i uses bits [i*W +: W].
- pol  in  N  per-channel output inversion.
- upd  in  1  single-cycle request to load the shadow inputs at the next boundary.
- cnt  out  W  active counter value.
- pwm  out  N  PWM outputs, registered.
- period_end  out  1  one-cycle pulse marking the first cycle of each new period.
- upd_pend  out  1  a load is pending.

Behaviour:
- Reset: rst_n sampled low at a clock edge clears the following.
  - Outputs: cnt=0, pwm=0, period_end=0.
  - Internal state: dir=up, active per_a=0, cmp_a=0, pol_a=0, mode_a=up.
  - upd_pend is set to 1, so the first enabled cycle loads the inputs.
- Reset overrides every other input. Asserting reset mid-period abandons the period.
- Last-cycle condition lc, by active mode:
  - up: cnt>=per_a.
  - down: cnt==0.
  - up-down: per_a==0, or cnt==1 with (dir==down or per_a==1).
- Counting when en=1 and not lc:
  - up: cnt+1.
  - down: cnt-1.
  - up-down, dir up: if cnt<per_a then cnt+1; if cnt==per_a then cnt-1 and dir<=down.
  - up-down, dir down: cnt-1.
- Period length:
  - up and down: per_a+1 cycles.
  - up-down: 2*per_a cycles (for example 0,1,..,P,P-1,..,1); 1 cycle when per_a=0.
- Boundary, when en=1 and lc:
  - If upd_pend or upd is high: per_a, cmp_a, pol_a and mode_a load from the inputs, and upd_pend clears.
  - cnt takes the start value of the (possibly new) mode: up and up-down start at 0; down starts at the new per_a.
  - dir<=up.
  - period_end=1 in the next cycle, i.e. the cycle in which cnt shows the start value. period_end is 0 in all other cycles.
- upd asserted outside a boundary edge: upd_pend becomes 1 on the next edge and holds until it is consumed. This applies whether en is high or low.
- upd asserted on the boundary edge itself loads immediately; upd_pend stays 0.
- en=0: cnt, dir, pwm and all active registers hold. period_end=0. No loads occur.
- PWM output:
  - pwm[i] = pol_a[i] XOR (cnt < cmp_a[i]).
  - Computed from next-state values and registered, so pwm aligns with cnt in the same cycle.
- PWM corner values (unsigned compare, no overflow):
  - cmp_a=0 gives 0% duty.
  - cmp_a>per_a gives 100% duty in up and down modes.
  - Up-down output is high around cnt=0, i.e. centered on the period edges.
- Arithmetic: all values unsigned W bits. cnt never leaves 0..per_a, so no wrap-around occurs.

Test Plan:
- Reset and first load (W=5, N=4)
  - Stimulus: per=9, cmp={31,10,3,0} (ch3..ch0), pol=0, mode=up; release rst_n with en=1.
  - Required: first enabled cycle loads; upd_pend falls; cnt runs 0..9 repeatedly; period_end every 10 cycles, coinciding with cnt=0.
  - Required duty: ch0 always 0; ch1 high at cnt 0..2; ch2 and ch3 always 1.
- Shadow update
  - Stimulus: at cnt=4, change ch1 cmp to 6 and pulse upd.
  - Required: upd_pend=1 from the next cycle until the boundary; ch1 pattern unchanged through cnt=9; from the period_end cycle onward ch1 is high at cnt 0..5.
- Down mode
  - Stimulus: mode=01, per=7, ch1 cmp=3, upd.
  - Required: after the boundary cnt=7,6,..,0; ch1 high only at cnt 2,1,0; period 8 cycles.
- Up-down mode
  - Stimulus: mode=10, per=4, ch1 cmp=2.
  - Required: cnt=0,1,2,3,4,3,2,1 repeating; ch1 high at the cnt values 0,1,1 (3 of 8 cycles); period_end every 8 cycles at cnt=0.
- Enable gap, polarity and per=0
  - Stimulus: drop en for 5 cycles mid-period and pulse upd during the gap.
  - Required: cnt and pwm frozen; period_end stays 0; upd_pend=1 with no load; counting resumes from the held value.
  - Stimulus: pol[0]=1 with cmp0=0. Required: ch0 constantly 1.
  - Stimulus: per=0. Required: cnt stays 0 and period_end=1 every enabled cycle.
- Mid-operation reset
  - Stimulus: drive rst_n low for 1 cycle at an arbitrary cnt.
  - Required: on the next cycle cnt=0, pwm=0, period_end=0, upd_pend=1.
  - Required: behaviour then matches scenario 1 using the current inputs.
